// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported synchronous RAM between the
// read-only fetch port and the read/write data port. Data accesses win
// arbitration until a streak of back-to-back data grants (with fetch
// waiting) saturates, then fetch gets exactly one grant.
`timescale 1ns/1ps

module mem_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned RD_LAT       = 1,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [DATA_W-1:0] data_o,
   input  logic [DATA_W-1:0] data_i,
   output logic              busy_o
);

   localparam int unsigned CNT_W    = 3;
   localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(RD_LAT - 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                owner_d_q, owner_d_d;   // 1 = data port owns the access
   logic                wr_q, wr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                busy_q, busy_d;

   // Next-state, arbitration and registered-output computation
   always_comb begin
      state_d   = state_q;
      owner_d_d = owner_d_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      streak_d  = streak_q;
      addr_d    = addr_q;
      data_d    = data_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      we_d      = 1'b0;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (d_req && !(i_req && (streak_q == STREAK_MAX))) begin
               state_d   = S_ACCESS;
               owner_d_d = 1'b1;
               wr_d      = d_we;
               we_d      = d_we;
               addr_d    = d_addr;
               data_d    = d_wdata;
               cnt_d     = '0;
               if (!i_req)
                  streak_d = '0;
               else if (streak_q != STREAK_MAX)
                  streak_d = streak_q + STREAK_W'(1);
            end else if (i_req) begin
               state_d   = S_ACCESS;
               owner_d_d = 1'b0;
               wr_d      = 1'b0;
               addr_d    = i_addr;
               cnt_d     = '0;
               streak_d  = '0;
            end
         end
         S_ACCESS: begin
            if (wr_q) begin
               // only the data port can own a write
               state_d = S_RESP;
               d_ack_d = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = S_RESP;
               if (owner_d_q) begin
                  d_rdata_d = data_i;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = data_i;
                  i_ack_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; async reset aborts any access in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         owner_d_q <= 1'b0;
         wr_q      <= 1'b0;
         cnt_q     <= '0;
         streak_q  <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         streak_q  <= streak_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         busy_q    <= busy_d;
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign data_o  = data_q;
   assign i_ack   = i_ack_q;
   assign d_ack   = d_ack_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. A RD_LAT=1 instance
// carries most scenarios; a RD_LAT=3 instance checks the longer read path.
`timescale 1ns/1ps

module tb_mem_arbiter;

   localparam int unsigned RDL  = 1;
   localparam int          MAXS = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we;
   logic [31:0] i_addr, d_addr, d_wdata;
   logic [31:0] i_rdata, d_rdata, addr_o, data_o, data_i;
   logic        i_ack, d_ack, we_o, busy_o;

   // second instance (RD_LAT = 3), data port only
   logic        i_req3, d_req3, d_we3;
   logic [31:0] i_addr3, d_addr3, d_wdata3;
   logic [31:0] i_rdata3, d_rdata3, addr_o3, data_o3, data_i3;
   logic        i_ack3, d_ack3, we_o3, busy_o3;

   // RAM environment
   bit   [31:0] ram [256];
   bit   [31:0] ref_mem [256];
   logic        ovr_en;
   logic [31:0] ovr_val;
   bit   [31:0] a3_p1, a3_p2;

   int checks   = 0;
   int failures = 0;
   int m_streak = 0;
   int cyc      = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RDL), .MAX_D_STREAK(MAXS)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .we_o(we_o), .addr_o(addr_o), .data_o(data_o), .data_i(data_i),
      .busy_o(busy_o)
   );

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_D_STREAK(MAXS)) u_dut3 (
      .clk(clk), .reset(reset),
      .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_ack(i_ack3),
      .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
      .d_rdata(d_rdata3), .d_ack(d_ack3),
      .we_o(we_o3), .addr_o(addr_o3), .data_o(data_o3), .data_i(data_i3),
      .busy_o(busy_o3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pat(input int idx);
      logic [31:0] a;
      a = 32'(idx + 1);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[9:2]);
   endfunction

   // RAM for the RD_LAT=1 instance: read data follows the address within the cycle
   always @(posedge clk) if (we_o) ram[addr_o[9:2]] <= data_o ^ pat(int'(addr_o[9:2]));
   assign data_i = ovr_en ? ovr_val : (ram[addr_o[9:2]] ^ pat(int'(addr_o[9:2])));

   // RAM for the RD_LAT=3 instance: data appears two edges after the address
   always @(posedge clk) begin
      a3_p1 <= addr_o3;
      a3_p2 <= a3_p1;
   end
   assign data_i3 = (a3_p2 == 32'h40) ? 32'hCAFE_F00D : 32'h0BAD_0BAD;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Arbitration reference: 0 = none, 1 = fetch, 2 = data
   task automatic model_pick(input bit ir, input bit dr, output int w);
      w = 0;
      if (dr && !(ir && m_streak == MAXS)) begin
         w = 2;
         if (!ir) m_streak = 0;
         else if (m_streak < MAXS) m_streak = m_streak + 1;
      end else if (ir) begin
         w = 1;
         m_streak = 0;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({we_o, i_ack, d_ack, busy_o} !== 4'b0) begin
         failures++; $display("FAIL reset_ctrl got=%b exp=0000", {we_o, i_ack, d_ack, busy_o});
      end
      checks++;
      if ({addr_o, data_o, i_rdata, d_rdata} !== 128'h0) begin
         failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", addr_o, data_o, i_rdata, d_rdata);
      end
      checks++;
      if ({busy_o3, d_ack3, d_rdata3} !== 34'h0) begin
         failures++; $display("FAIL reset_dut3 got=%b %b %h exp=0", busy_o3, d_ack3, d_rdata3);
      end
      reset = 1'b1;
      m_streak = 0;
   endtask

   task automatic test_single_fetch;
      int w;
      ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
      i_req = 1'b1; i_addr = 32'h100;
      model_pick(1'b1, 1'b0, w);
      tick;
      checks++;
      if (addr_o !== 32'h100 || we_o !== 1'b0 || i_ack !== 1'b0) begin
         failures++; $display("FAIL fetch_access got=addr %h we %b ack %b exp=addr 100 we 0 ack 0", addr_o, we_o, i_ack);
      end
      tick;
      checks++;
      if (i_ack !== 1'b1 || d_ack !== 1'b0 || we_o !== 1'b0) begin
         failures++; $display("FAIL fetch_ack got=i %b d %b we %b exp=1 0 0", i_ack, d_ack, we_o);
      end
      checks++;
      if (i_rdata !== 32'hDEAD_BEEF) begin
         failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", i_rdata);
      end
      tick;
      i_req = 1'b0; ovr_en = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || i_ack !== 1'b0) begin
         failures++; $display("FAIL fetch_idle got=busy %b ack %b exp=0 0", busy_o, i_ack);
      end
   endtask

   task automatic test_data_write;
      int w;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678;
      model_pick(1'b0, 1'b1, w);
      tick;
      checks++;
      if (we_o !== 1'b1 || addr_o !== 32'h200 || data_o !== 32'h1234_5678 || d_ack !== 1'b0) begin
         failures++; $display("FAIL write_access got=we %b addr %h data %h ack %b exp=1 200 12345678 0", we_o, addr_o, data_o, d_ack);
      end
      tick;
      ref_mem[widx(32'h200)] = 32'h1234_5678;
      checks++;
      if (we_o !== 1'b0 || d_ack !== 1'b1 || i_ack !== 1'b0) begin
         failures++; $display("FAIL write_resp got=we %b d %b i %b exp=0 1 0", we_o, d_ack, i_ack);
      end
      tick;
      d_req = 1'b0; d_we = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || we_o !== 1'b0 || d_ack !== 1'b0 || i_ack !== 1'b0) begin
         failures++; $display("FAIL write_idle got=busy %b we %b d %b i %b exp=0", busy_o, we_o, d_ack, i_ack);
      end
   endtask

   task automatic test_contention;
      int w, want;
      logic [31:0] ia, da;
      ia = 32'h800; da = 32'hC00;
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      for (int t = 0; t < 20; t++) begin
         i_addr = ia; d_addr = da;
         want = (t % 5 == 4) ? 1 : 2;
         model_pick(1'b1, 1'b1, w);
         for (int k = 1; k <= int'(RDL) + 1; k++) begin
            tick;
            checks++;
            if (i_ack === 1'b1 && d_ack === 1'b1) begin
               failures++; $display("FAIL cont_dual_ack txn %0d got=both exp=one", t);
            end
         end
         checks++;
         if (i_ack !== (want == 1) || d_ack !== (want == 2)) begin
            failures++; $display("FAIL cont_order txn %0d got=i %b d %b exp=%s", t, i_ack, d_ack, (want == 1) ? "I" : "D");
         end
         checks++;
         if (want == 1 && i_rdata !== ref_mem[widx(ia)]) begin
            failures++; $display("FAIL cont_i_rdata txn %0d got=%h exp=%h", t, i_rdata, ref_mem[widx(ia)]);
         end else if (want == 2 && d_rdata !== ref_mem[widx(da)]) begin
            failures++; $display("FAIL cont_d_rdata txn %0d got=%h exp=%h", t, d_rdata, ref_mem[widx(da)]);
         end
         tick;
         if (want == 1) ia = ia + 32'd4; else da = da + 32'd4;
      end
      i_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_rdlat3;
      int ack_at, busy_cnt, acks;
      logic [31:0] rd;
      ack_at = -1; busy_cnt = 0; acks = 0; rd = '0;
      d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h40;
      for (int k = 1; k <= 7; k++) begin
         tick;
         if (busy_o3 === 1'b1) busy_cnt++;
         if (d_ack3 === 1'b1) begin
            acks++;
            ack_at = k;
            rd = d_rdata3;
         end
         if (k == 5) d_req3 = 1'b0;
      end
      checks++;
      if (ack_at != 4 || acks != 1) begin
         failures++; $display("FAIL lat3_ack_cycle got=%0d (count %0d) exp=4 (count 1)", ack_at, acks);
      end
      checks++;
      if (busy_cnt != 4) begin
         failures++; $display("FAIL lat3_busy got=%0d exp=4", busy_cnt);
      end
      checks++;
      if (rd !== 32'hCAFE_F00D) begin
         failures++; $display("FAIL lat3_rdata got=%h exp=cafef00d", rd);
      end
   endtask

   task automatic test_back_to_back;
      int w, n;
      int ack_cyc [3];
      logic [31:0] a;
      n = 0; a = 32'h0;
      i_req = 1'b1; i_addr = a; d_req = 1'b0;
      model_pick(1'b1, 1'b0, w);
      for (int k = 0; k < 12 && n < 3; k++) begin
         tick;
         if (i_ack === 1'b1) begin
            ack_cyc[n] = cyc;
            checks++;
            if (i_rdata !== ref_mem[widx(a)]) begin
               failures++; $display("FAIL b2b_rdata addr %h got=%h exp=%h", a, i_rdata, ref_mem[widx(a)]);
            end
            n++;
            a = a + 32'd4;
            i_addr = a;
            if (n == 3) i_req = 1'b0;
            else model_pick(1'b1, 1'b0, w);
         end
      end
      tick;
      checks++;
      if (n != 3) begin
         failures++; $display("FAIL b2b_count got=%0d exp=3", n);
      end else begin
         checks++;
         if (ack_cyc[1] - ack_cyc[0] != int'(RDL) + 2 || ack_cyc[2] - ack_cyc[1] != int'(RDL) + 2) begin
            failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=%0d", ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1], RDL + 2);
         end
      end
   endtask

   task automatic test_reset_mid_write;
      int w;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5A5_5A5A;
      model_pick(1'b0, 1'b1, w);
      tick;
      checks++;
      if (we_o !== 1'b1) begin
         failures++; $display("FAIL rstw_we_before got=%b exp=1", we_o);
      end
      #1 reset = 1'b0;
      #1;
      checks++;
      if ({we_o, i_ack, d_ack, busy_o} !== 4'b0 || {addr_o, data_o, i_rdata, d_rdata} !== 128'h0) begin
         failures++; $display("FAIL rstw_async got=we %b busy %b addr %h data %h exp=0", we_o, busy_o, addr_o, data_o);
      end
      d_req = 1'b0; d_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         checks++;
         if (d_ack !== 1'b0 || we_o !== 1'b0) begin
            failures++; $display("FAIL rstw_no_ack got=d %b we %b exp=0 0", d_ack, we_o);
         end
      end
      reset = 1'b1;
      m_streak = 0;
      tick;
      i_req = 1'b1; i_addr = 32'h104;
      model_pick(1'b1, 1'b0, w);
      tick;
      checks++;
      if (addr_o !== 32'h104 || busy_o !== 1'b1) begin
         failures++; $display("FAIL rstw_refetch_addr got=%h busy %b exp=104 1", addr_o, busy_o);
      end
      tick;
      checks++;
      if (i_ack !== 1'b1 || i_rdata !== ref_mem[widx(32'h104)]) begin
         failures++; $display("FAIL rstw_refetch got=ack %b data %h exp=1 %h", i_ack, i_rdata, ref_mem[widx(32'h104)]);
      end
      tick;
      i_req = 1'b0;
      tick;
   endtask

   task automatic test_random;
      bit ip, dp, dwe, i_seen, d_seen;
      logic [31:0] ia, da, dw, exp_i, exp_d, exp_a;
      int w, lat;
      ip = 0; dp = 0; dwe = 0; i_seen = 0; d_seen = 0;
      ia = '0; da = '0; dw = '0; exp_i = '0; exp_d = '0;
      for (int it = 0; it < 120; it++) begin
         if (!ip && $urandom_range(1, 0) == 1) begin
            ip = 1; ia = 32'($urandom_range(31, 0)) << 2;
         end
         if (!dp && $urandom_range(2, 0) != 0) begin
            dp = 1; dwe = ($urandom_range(1, 0) == 1);
            da = 32'($urandom_range(31, 0)) << 2; dw = $urandom;
         end
         i_req = ip; i_addr = ia; d_req = dp; d_we = dwe; d_addr = da; d_wdata = dw;
         model_pick(ip, dp, w);
         if (w == 0) begin
            tick;
            checks++;
            if (busy_o !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
               failures++; $display("FAIL rnd_idle it %0d got=busy %b i %b d %b exp=0", it, busy_o, i_ack, d_ack);
            end
            continue;
         end
         lat = (w == 2 && dwe) ? 2 : int'(RDL) + 1;
         exp_a = (w == 2) ? da : ia;
         for (int k = 1; k <= lat; k++) begin
            tick;
            if (k == 1) begin
               checks++;
               if (addr_o !== exp_a || we_o !== (w == 2 && dwe) || ((w == 2 && dwe) && data_o !== dw)) begin
                  failures++; $display("FAIL rnd_access it %0d got=addr %h we %b data %h exp=addr %h we %b data %h", it, addr_o, we_o, data_o, exp_a, (w == 2 && dwe), dw);
               end
            end
            checks++;
            if (busy_o !== 1'b1 || i_ack !== (k == lat && w == 1) || d_ack !== (k == lat && w == 2)) begin
               failures++; $display("FAIL rnd_ack it %0d cyc %0d got=busy %b i %b d %b exp=1 %b %b", it, k, busy_o, i_ack, d_ack, (k == lat && w == 1), (k == lat && w == 2));
            end
         end
         if (w == 1) begin
            exp_i = ref_mem[widx(ia)]; i_seen = 1;
         end else if (!dwe) begin
            exp_d = ref_mem[widx(da)]; d_seen = 1;
         end else begin
            ref_mem[widx(da)] = dw;
         end
         checks++;
         if (i_seen && i_rdata !== exp_i) begin
            failures++; $display("FAIL rnd_i_rdata it %0d got=%h exp=%h", it, i_rdata, exp_i);
         end
         checks++;
         if (d_seen && d_rdata !== exp_d) begin
            failures++; $display("FAIL rnd_d_rdata it %0d got=%h exp=%h", it, d_rdata, exp_d);
         end
         tick;
         checks++;
         if (busy_o !== 1'b0 || we_o !== 1'b0) begin
            failures++; $display("FAIL rnd_post it %0d got=busy %b we %b exp=0 0", it, busy_o, we_o);
         end
         if (w == 1) ip = 0; else dp = 0;
      end
      i_req = 1'b0; d_req = 1'b0;
      tick;
   endtask

   initial begin
      i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      i_req3 = 0; i_addr3 = '0; d_req3 = 0; d_we3 = 0; d_addr3 = '0; d_wdata3 = '0;
      ovr_en = 0; ovr_val = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
      test_reset;
      test_single_fetch;
      test_data_write;
      test_contention;
      test_rdlat3;
      test_back_to_back;
      test_reset_mid_write;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the CPU's single-ported RAM interface (`we_o`, `addr_o`, `data_o`, `data_i`). It shares that port between the fetch path (read-only instruction port) and the load/store path (read/write data port).
- Each access runs as a small FSM with a req/ack handshake and registered RAM-side outputs.
- It handles a configurable synchronous read latency.
- Data accesses have priority, bounded by an anti-starvation streak counter so fetch always makes progress.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `RD_LAT`, 1: cycles from `addr_o` valid to `data_i` valid; legal range 1..4.
- `MAX_D_STREAK`, 4: maximum consecutive data grants while fetch waits; must be at least 1.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held high with `i_addr` stable until `i_ack`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_rdata`  out  DATA_W  fetch read data; valid in the `i_ack` cycle, held until the next `i_ack`.
- `i_ack`  out  1  one-cycle completion pulse, fetch port.
- `d_req`  in  1  data request; held high with `d_we`, `d_addr`, `d_wdata` stable until `d_ack`.
- `d_we`  in  1  1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  write data.
- `d_rdata`  out  DATA_W  data read result; valid in the `d_ack` cycle, held until the next `d_ack` of a read.
- `d_ack`  out  1  one-cycle completion pulse, data port.
- `we_o`  out  1  RAM write enable.
- `addr_o`  out  ADDR_W  RAM address.
- `data_o`  out  DATA_W  RAM write data.
- `data_i`  in  DATA_W  RAM read data.
- `busy_o`  out  1  high whenever the FSM is not in IDLE.

## Operation
**FSM states:** IDLE, ACCESS, RESP.

**IDLE (arbitration happens only here):**
- Grant D if `d_req` is high and not (`i_req` high and `streak == MAX_D_STREAK`).
- Otherwise grant I if `i_req` is high.
- Otherwise stay in IDLE.

**Grant edge:**
- Register `addr_o` from the winner's address.
- Register `data_o` from `d_wdata` (D grant) or hold it (I grant).
- Latch the owner and write flag; clear the latency counter; go to ACCESS.

**Streak counter:**
- On a D grant: if `i_req` is high, increment (saturating at `MAX_D_STREAK`); otherwise clear to 0.
- On an I grant: clear to 0.

**ACCESS, write:**
- `we_o` = 1 for exactly one cycle, then go to RESP.

**ACCESS, read:**
- Stays `RD_LAT` cycles with `we_o` = 0.
- On the edge ending the last ACCESS cycle, capture `data_i` into the owner's rdata register and go to RESP.

**RESP:**
- Owner's ack = 1 for one cycle, then go to IDLE.
- The requester drops or changes its req on the edge ending RESP, so IDLE always sees post-ack request state.
- There is no re-grant from a stale req.

**Output rules:**
- `addr_o` and `data_o` hold their last values outside transactions.
- `we_o` is 1 only in a write ACCESS cycle.
- An instruction-port write is impossible (the port is read-only).

**Reset (asynchronous, active-low):**
- FSM goes to IDLE.
- `we_o`, `i_ack`, `d_ack`, `busy_o`, `addr_o`, `data_o`, `i_rdata`, `d_rdata`, streak and counter all go to 0.
- Reset asserted mid-transaction aborts it: `we_o` drops immediately and no ack is ever issued for the aborted access.

## Timing
**Latency, from the IDLE cycle with req sampled high to the ack cycle:**
- Write: 2 cycles (ACCESS, RESP).
- Read: `RD_LAT` + 1 cycles.

**Throughput:**
- Minimum spacing between grants: write 3 cycles, read `RD_LAT` + 2 cycles (one IDLE cycle per transaction).

**Simultaneous requests:**
- `i_req` and `d_req` high together: D wins until the streak saturates, then I wins exactly once.

**Starvation bound:**
- With both requesters continuously requesting, the grant order is `MAX_D_STREAK` D grants then 1 I grant, repeating.

**Read data:**
- `i_rdata` and `d_rdata` are registered; they change only on their own read completion.
- They are unaffected by the other port's transactions.

**Sampling:**
- Request inputs are sampled only in IDLE.
- Changes to address or data during ACCESS/RESP are ignored; outputs use the registered copies.

## Test plan
- **Single fetch, `RD_LAT` = 1:**
  - Stimulus: `i_req`, `i_addr` = 0x100; RAM returns 0xDEADBEEF.
  - Required: `addr_o` = 0x100 one cycle later; `i_ack` two cycles after IDLE sample with `i_rdata` = 0xDEADBEEF; `we_o` stays 0.
- **Data write:**
  - Stimulus: `d_req`, `d_we` = 1, `d_addr` = 0x200, `d_wdata` = 0x12345678.
  - Required: exactly one cycle with `we_o` = 1, `addr_o` = 0x200, `data_o` = 0x12345678; `d_ack` the next cycle; `i_ack` never asserted.
- **Contention, `MAX_D_STREAK` = 4:**
  - Stimulus: `i_req` and `d_req` (reads) held high for 20 transactions.
  - Required: grant order D,D,D,D,I repeating; no ack ever on both ports in the same cycle.
- **`RD_LAT` = 3 read:**
  - Stimulus: `d_req` read at 0x40; RAM data valid 3 cycles after the address.
  - Required: `d_ack` 4 cycles after IDLE sample with the correct `d_rdata`; `busy_o` high for 4 cycles.
- **Reset mid-write:**
  - Stimulus: assert `reset` low during the write ACCESS cycle.
  - Required: `we_o` drops to 0 asynchronously; no `d_ack`; all outputs 0; after release a new `i_req` completes normally.
- **Back-to-back fetches:**
  - Stimulus: `i_req` kept high with the address changed on each `i_ack` edge (0x0, 0x4, 0x8).
  - Required: three grants spaced `RD_LAT` + 2 cycles apart, each `i_rdata` matching its address.
